// File: rtl/pingpong_decoder.sv
// rtl/pingpong_decoder.sv - recovers pingpong accumulator operands from its register stream
// Optional sticky negative-operand check: PINGPONG_DEC_NONNEG_CHECK_EN
module pingpong_decoder #(
    parameter logic signed [31:0] MAX_THRESHOLD = 32'sd100,
    parameter logic signed [31:0] MIN_THRESHOLD = 32'sd0,
    parameter int                 CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic signed [31:0]      reg_value,
    input  logic                    sync_load,
    input  logic                    sync_dir,
    output logic                    out_valid,
    output logic signed [31:0]      out_number,
    output logic                    out_dir,
    output logic                    bounce,
    output logic [CNT_W-1:0]        sample_cnt,
    output logic                    err_flag
);

    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    logic signed [31:0] prev;
    logic        [31:0] delta;
    logic        [31:0] number_nxt;
    logic               decode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_UP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        decode     = sample_valid && !sync_load;
        delta      = reg_value - prev;
        number_nxt = (state == ST_UP) ? delta : (32'd0 - delta);
        state_nxt  = state;
        if (sync_load) begin
            state_nxt = sync_dir ? ST_UP : ST_DOWN;
        end else if (sample_valid) begin
            // Already-DOWN above MAX (or already-UP below MIN) keeps its state.
            if ((state == ST_UP) && (reg_value > MAX_THRESHOLD)) begin
                state_nxt = ST_DOWN;
            end else if ((state == ST_DOWN) && (reg_value < MIN_THRESHOLD)) begin
                state_nxt = ST_UP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            out_valid  <= 1'b0;
            out_number <= '0;
            out_dir    <= 1'b1;
            bounce     <= 1'b0;
            sample_cnt <= '0;
        end else begin
            out_valid <= decode;
            bounce    <= decode && (state_nxt != state);
            if (sync_load) begin
                prev       <= reg_value;
                sample_cnt <= '0;
            end else if (sample_valid) begin
                prev       <= reg_value;
                out_number <= number_nxt;
                out_dir    <= (state == ST_UP);
                if (sample_cnt != CNT_MAX) begin
                    sample_cnt <= sample_cnt + CNT_ONE;
                end
            end
        end
    end

`ifdef PINGPONG_DEC_NONNEG_CHECK_EN
    logic err_q;

    // Registered alongside out_number so it rises with the offending pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (decode && number_nxt[31]) begin
            err_q <= 1'b1;
        end
    end

    assign err_flag = err_q;
`else
    assign err_flag = 1'b0;
`endif

endmodule
